// File: rtl/lock_code_player_if.sv
// Button-side bus of the lock code player: request/code in, button pulses and
// status out, plus the unlock feedback from the lock.
interface lock_code_player_if #(
  parameter int CODE_LEN = 4
);
  logic                start;
  logic [CODE_LEN-1:0] code;
  logic                unlock;
  logic                btn_0;
  logic                btn_1;
  logic                busy;
  logic                done;
  logic                success;

  modport master (
    output start, code, unlock,
    input  btn_0, btn_1, busy, done, success
  );

  modport slave (
    input  start, code, unlock,
    output btn_0, btn_1, busy, done, success
  );
endinterface

// File: rtl/lock_code_player.sv
// Plays a latched binary code MSB-first as btn_0/btn_1 press pulses, then waits
// a bounded time for unlock and reports success with a one-cycle done pulse.
module lock_code_player #(
  parameter int CODE_LEN = 4,
  parameter int PULSE    = 1,
  parameter int GAP      = 1,
  parameter int TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              btn_reset,
  lock_code_player_if.slave bus
);

  localparam int BW   = $clog2(CODE_LEN) + 1;
  localparam int WW   = $clog2(TIMEOUT) + 1;
  localparam int CMAX = (PULSE > GAP) ? PULSE : GAP;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(CODE_LEN - 1);
  localparam logic [CW-1:0] PULSE_C  = CW'(PULSE);
  localparam logic [CW-1:0] GAP_C    = CW'(GAP);
  localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_WAIT,
    S_FIN
  } state_t;

  state_t              state, state_n;
  logic [CODE_LEN-1:0] sr, sr_n;
  logic [BW-1:0]       bit_cnt, bit_cnt_n;
  logic [CW-1:0]       cyc_cnt, cyc_cnt_n;
  logic [WW-1:0]       wait_cnt, wait_cnt_n;
  logic                btn_0_n, btn_1_n, busy_n, done_n, success_n;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      state       <= S_IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      cyc_cnt     <= '0;
      wait_cnt    <= '0;
      bus.btn_0   <= 1'b0;
      bus.btn_1   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.success <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      bit_cnt     <= bit_cnt_n;
      cyc_cnt     <= cyc_cnt_n;
      wait_cnt    <= wait_cnt_n;
      bus.btn_0   <= btn_0_n;
      bus.btn_1   <= btn_1_n;
      bus.busy    <= busy_n;
      bus.done    <= done_n;
      bus.success <= success_n;
    end
  end

  // Outputs are computed one cycle ahead here and registered above.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_n    = state;
    sr_n       = sr;
    bit_cnt_n  = bit_cnt;
    cyc_cnt_n  = cyc_cnt + CW'(!(&cyc_cnt));
    wait_cnt_n = wait_cnt;
    btn_0_n    = bus.btn_0;
    btn_1_n    = bus.btn_1;
    busy_n     = bus.busy;
    done_n     = 1'b0;
    success_n  = bus.success;

    unique case (state)
      S_IDLE: begin
        btn_0_n = 1'b0;
        btn_1_n = 1'b0;
        busy_n  = 1'b0;
        if (bus.start) begin
          state_n   = S_PRESS;
          sr_n      = bus.code;
          bit_cnt_n = '0;
          cyc_cnt_n = CYC_ONE;
          btn_1_n   = bus.code[CODE_LEN-1];
          btn_0_n   = !bus.code[CODE_LEN-1];
          busy_n    = 1'b1;
          success_n = 1'b0;
        end
      end

      S_PRESS: begin
        if (cyc_cnt >= PULSE_C) begin
          btn_0_n   = 1'b0;
          btn_1_n   = 1'b0;
          cyc_cnt_n = CYC_ONE;
          if (bit_cnt >= LAST_BIT) begin
            state_n    = S_WAIT;
            wait_cnt_n = '0;
          end else begin
            state_n   = S_GAP;
            sr_n      = sr << 1;
            bit_cnt_n = bit_cnt + BW'(!(&bit_cnt));
          end
        end
      end

      S_GAP: begin
        // The shift already happened on entry, so the MSB is the next bit.
        if (cyc_cnt >= GAP_C) begin
          state_n   = S_PRESS;
          cyc_cnt_n = CYC_ONE;
          btn_1_n   = sr[CODE_LEN-1];
          btn_0_n   = !sr[CODE_LEN-1];
        end
      end

      S_WAIT: begin
        if (bus.unlock) begin
          state_n   = S_FIN;
          success_n = 1'b1;
          done_n    = 1'b1;
          busy_n    = 1'b0;
        end else if (wait_cnt >= TMO_LAST) begin
          state_n   = S_FIN;
          success_n = 1'b0;
          done_n    = 1'b1;
          busy_n    = 1'b0;
        end else begin
          wait_cnt_n = wait_cnt + WW'(!(&wait_cnt));
        end
      end

      S_FIN: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lock_code_player.sv
// Directed bench: default instance for waveform/unlock/timeout/robustness, and a
// CODE_LEN=3/PULSE=2/GAP=3 instance wired to a small behavioural lock.
module tb_lock_code_player;

  logic clk = 1'b0;
  logic btn_reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lock_code_player_if #(.CODE_LEN(4)) if_a ();
  lock_code_player_if #(.CODE_LEN(3)) if_b ();

  lock_code_player #(.CODE_LEN(4), .PULSE(1), .GAP(1), .TIMEOUT(8)) u_dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .bus       (if_a.slave)
  );

  lock_code_player #(.CODE_LEN(3), .PULSE(2), .GAP(3), .TIMEOUT(8)) u_dut_b (
    .clk       (clk),
    .btn_reset (btn_reset),
    .bus       (if_b.slave)
  );

  // Behavioural lock for the second instance: counts press rising edges and
  // raises unlock once three presses match the secret.
  logic [2:0] lock_secret;
  logic [2:0] sh;
  logic       p0, p1;
  int         pc;

  always @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      sh <= '0; pc <= 0; p0 <= 1'b0; p1 <= 1'b0; if_b.unlock <= 1'b0;
    end else if (if_b.start) begin
      sh <= '0; pc <= 0; p0 <= 1'b0; p1 <= 1'b0; if_b.unlock <= 1'b0;
    end else begin
      p0 <= if_b.btn_0;
      p1 <= if_b.btn_1;
      if ((if_b.btn_0 && !p0) || (if_b.btn_1 && !p1)) begin
        sh <= {sh[1:0], if_b.btn_1};
        pc <= pc + 1;
      end
      if (pc == 3 && sh == lock_secret) if_b.unlock <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_b0"},   32'(if_a.btn_0), 0);
    check({tag, "_b1"},   32'(if_a.btn_1), 0);
    check({tag, "_busy"}, 32'(if_a.busy),  0);
    check({tag, "_done"}, 32'(if_a.done),  0);
  endtask

  // Plays code c on instance A; cycle k means the cycle after edge T+k-1.
  task automatic run_seq(input logic [3:0] c, input int unlock_k, input int restart_k,
                         input int done_k, input logic succ,
                         input logic [16:1] e_b1, input logic [16:1] e_b0,
                         input logic [16:1] e_busy);
    @(negedge clk);
    if_a.code  = c;
    if_a.start = 1'b1;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      check($sformatf("b1@T+%0d", k),   32'(if_a.btn_1), 32'(e_b1[k]));
      check($sformatf("b0@T+%0d", k),   32'(if_a.btn_0), 32'(e_b0[k]));
      check($sformatf("excl@T+%0d", k), 32'(if_a.btn_0 & if_a.btn_1), 0);
      check($sformatf("busy@T+%0d", k), 32'(if_a.busy),  32'(e_busy[k]));
      check($sformatf("done@T+%0d", k), 32'(if_a.done),  32'(k == done_k));
      if (k == 1)      check("succ_clr", 32'(if_a.success), 0);
      if (k == done_k) check("succ_fin", 32'(if_a.success), 32'(succ));
      if_a.start  = (k == restart_k);
      if_a.unlock = (k == unlock_k);
      if (k == 2) if_a.code = ~c;
    end
    if_a.start  = 1'b0;
    if_a.unlock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d", k), 32'(if_a.success), 32'(succ));
      check_idle_a($sformatf("post%0d", k));
    end
  endtask

  task automatic run_b(input logic [2:0] c, input logic exp_succ);
    logic [16:1] e_b0 = 16'b0000_1100_0000_0011;
    logic [16:1] e_b1 = 16'b0000_0000_0110_0000;
    int          seen = 0;
    @(negedge clk);
    if_b.code  = c;
    if_b.start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if_b.start = 1'b0;
      check($sformatf("p6_b0@T+%0d", k),   32'(if_b.btn_0), 32'(e_b0[k]));
      check($sformatf("p6_b1@T+%0d", k),   32'(if_b.btn_1), 32'(e_b1[k]));
      check($sformatf("p6_busy@T+%0d", k), 32'(if_b.busy),  1);
    end
    for (int k = 0; k < 30 && seen == 0; k++) begin
      @(negedge clk);
      if (if_b.done) seen = 1;
    end
    check("p6_done_seen", 32'(seen), 1);
    check("p6_success",   32'(if_b.success), 32'(exp_succ));
  endtask

  initial begin
    btn_reset   = 1'b1;
    if_a.start  = 1'b0;
    if_a.code   = '0;
    if_a.unlock = 1'b0;
    if_b.start  = 1'b0;
    if_b.code   = '0;
    lock_secret = 3'b010;

    // Reset and quiet idle
    repeat (2) @(negedge clk);
    check_idle_a("rst");
    check("rst_succ", 32'(if_a.success), 0);
    btn_reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_idle_a($sformatf("idle%0d", k));
      check($sformatf("idle%0d_succ", k), 32'(if_a.success), 0);
    end

    // Play 1001 with timeout: done at T+16
    run_seq(4'b1001, 0, 0, 16, 1'b0,
            16'b0000_0000_0100_0001, 16'b0000_0000_0001_0100,
            16'b0111_1111_1111_1111);
    // Unlock at T+9: done/success at T+10
    run_seq(4'b1001, 9, 0, 10, 1'b1,
            16'b0000_0000_0100_0001, 16'b0000_0000_0001_0100,
            16'b0000_0001_1111_1111);
    // Start re-pulsed at T+4 is ignored; also clears previous success
    run_seq(4'b1001, 0, 4, 16, 1'b0,
            16'b0000_0000_0100_0001, 16'b0000_0000_0001_0100,
            16'b0111_1111_1111_1111);
    // Unlock on the final WAIT cycle still counts
    run_seq(4'b0110, 15, 0, 16, 1'b1,
            16'b0000_0000_0001_0100, 16'b0000_0000_0100_0001,
            16'b0111_1111_1111_1111);

    // Mid-sequence reset at T+5
    @(negedge clk);
    if_a.code  = 4'b1001;
    if_a.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if_a.start = 1'b0;
      check($sformatf("r_b0@T+%0d", k), 32'(if_a.btn_0), 32'(k == 3 || k == 5));
    end
    btn_reset = 1'b1;
    #1;
    check("r_drop_b0", 32'(if_a.btn_0), 0);
    check("r_drop_busy", 32'(if_a.busy), 0);
    @(negedge clk);
    btn_reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_idle_a($sformatf("r_after%0d", k));
    end

    // Parameterised instance against the behavioural lock
    lock_secret = 3'b010;
    run_b(3'b010, 1'b1);
    lock_secret = 3'b011;
    run_b(3'b010, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
